// File: rtl/dcache_wb_dm.sv
// rtl/dcache_wb_dm.sv - direct-mapped write-back write-allocate data cache
// Hits finish in the request cycle; misses stall through optional write-back and refill.
module dcache_wb_dm #(
   parameter int NUM_BLOCKS      = 8,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic [31:0]  proc_rdata,
   output logic         proc_stall,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int TAG_W = 30 - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t state, state_nxt;

   logic [NUM_BLOCKS-1:0] valid_q;
   logic [NUM_BLOCKS-1:0] dirty_q;
   logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
   logic [127:0]          data_q [NUM_BLOCKS];

   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             req;
   logic             hit;
   logic [127:0]     line;
   logic [31:0]      word_sel;
   logic             refill;
   logic             store_hit;

   assign off       = proc_addr[OFF_W-1:0];
   assign idx       = proc_addr[OFF_W +: IDX_W];
   assign tag       = proc_addr[29 -: TAG_W];
   assign req       = proc_read | proc_write;
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign line      = data_q[idx];
   assign word_sel  = line[{off, 5'd0} +: 32];
   assign refill    = (state == ALLOCATE) && mem_ready;
   assign store_hit = (state == IDLE) && proc_write && hit;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req && !hit) begin
               state_nxt = dirty_q[idx] ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            if (mem_ready) begin
               state_nxt = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (mem_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The victim address comes from the stored tag; the refill address from the request.
   always_comb begin
      proc_stall = 1'b0;
      proc_rdata = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = proc_addr[29:OFF_W];
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            proc_stall = req && !hit;
            if (proc_read && !proc_write && hit) begin
               proc_rdata = word_sel;
            end
         end
         WRITEBACK: begin
            proc_stall = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {tag_q[idx], idx};
            mem_wdata  = line;
         end
         ALLOCATE: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (refill) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid_q alone qualifies them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (refill) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= tag;
         end else if (store_hit) begin
            data_q[idx][{off, 5'd0} +: 32] <= proc_wdata;
         end
      end
   end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// tb/tb_dcache_wb_dm.sv - randomized self-checking bench for dcache_wb_dm
// Main memory and an architectural value/line-state model live in the bench.
module tb_dcache_wb_dm;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         proc_read = 1'b0;
   logic         proc_write = 1'b0;
   logic [29:0]  proc_addr = '0;
   logic [31:0]  proc_wdata = '0;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;

   dcache_wb_dm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] bmem   [int];
   logic [31:0] golden [int];
   bit          m_valid [8];
   bit          m_dirty [8];
   logic [24:0] m_tag   [8];

   int           txn_wr   [$];
   logic [27:0]  txn_addr [$];
   logic [127:0] txn_data [$];
   int           txn_lat  [$];
   int           stall_cycles;
   logic [31:0]  rdata_obs;
   bit           timeout;
   bit           proto_err;

   function automatic logic [31:0] init_word(int a);
      return (a * 32'h9E3779B1) ^ 32'h13572468;
   endfunction

   function automatic logic [31:0] bword(int a);
      return bmem.exists(a) ? bmem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] gword(int a);
      return golden.exists(a) ? golden[a] : bword(a);
   endfunction

   function automatic logic [127:0] bblock(int b);
      logic [127:0] r;
      for (int w = 0; w < 4; w++) r[w*32 +: 32] = bword(b*4 + w);
      return r;
   endfunction

   function automatic logic [127:0] gblock(int b);
      logic [127:0] r;
      for (int w = 0; w < 4; w++) r[w*32 +: 32] = gword(b*4 + w);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
      golden.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b1;
      proc_read = 1'b0;
      proc_write = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
   endtask

   // Presents one request at a negedge and plays main memory until the cache releases it.
   task automatic do_access(input bit rd, input bit wr, input logic [29:0] addr,
                            input logic [31:0] wd, input int lat_fix);
      int cnt, cur_lat, b;
      bit done;
      logic [27:0] cur_addr;
      proc_read = rd;
      proc_write = wr;
      proc_addr = addr;
      proc_wdata = wd;
      txn_wr.delete();
      txn_addr.delete();
      txn_data.delete();
      txn_lat.delete();
      stall_cycles = 0;
      proto_err = 1'b0;
      rdata_obs = '0;
      done = 1'b0;
      cnt = 0;
      cur_lat = 1;
      cur_addr = '0;
      for (int c = 0; c < 100 && !done; c++) begin
         #1;
         if (mem_read && mem_write) proto_err = 1'b1;
         if (mem_read || mem_write) begin
            if (cnt == 0) begin
               cur_lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 5));
               cur_addr = mem_addr;
               txn_wr.push_back(mem_write ? 1 : 0);
               txn_addr.push_back(mem_addr);
               txn_data.push_back(mem_wdata);
               txn_lat.push_back(cur_lat);
            end else if (mem_addr !== cur_addr) begin
               proto_err = 1'b1;
            end
            cnt++;
            if (cnt == cur_lat) begin
               b = int'(mem_addr);
               mem_ready = 1'b1;
               cnt = 0;
               if (mem_write) begin
                  for (int w = 0; w < 4; w++) bmem[b*4 + w] = mem_wdata[w*32 +: 32];
               end else begin
                  mem_rdata = bblock(b);
               end
            end
         end
         if (!proc_stall) begin
            done = 1'b1;
            rdata_obs = proc_rdata;
         end else begin
            stall_cycles++;
         end
         @(negedge clk);
         mem_ready = 1'b0;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      timeout = !done;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if (proc_stall !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b expected 0", proc_stall);
      end
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++; $display("FAIL reset_mem_req: got rd=%b wr=%b expected 0 0", mem_read, mem_write);
      end
      checks++;
      if (proc_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_rdata: got %h expected 0", proc_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_cold_read();
      do_access(1'b1, 1'b0, 30'h5, 32'h0, 4);
      checks++;
      if (timeout || proto_err) begin
         errors++; $display("FAIL cold_read_proto: timeout=%b proto=%b expected 0 0", timeout, proto_err);
      end
      checks++;
      if (txn_wr.size() !== 1 || txn_wr[0] !== 0 || txn_addr[0] !== 28'h1) begin
         errors++; $display("FAIL cold_read_txn: got n=%0d wr=%0d addr=%h expected 1 read at 1",
                            txn_wr.size(), txn_wr[0], txn_addr[0]);
      end
      checks++;
      if (stall_cycles !== 5) begin
         errors++; $display("FAIL cold_read_stall: got %0d expected 5", stall_cycles);
      end
      checks++;
      if (rdata_obs !== init_word(5)) begin
         errors++; $display("FAIL cold_read_rdata: got %h expected %h", rdata_obs, init_word(5));
      end
   endtask

   task automatic test_write_hit();
      do_access(1'b0, 1'b1, 30'h5, 32'hDEADBEEF, 0);
      golden[5] = 32'hDEADBEEF;
      checks++;
      if (stall_cycles !== 0 || txn_wr.size() !== 0) begin
         errors++; $display("FAIL write_hit_stall: got stall=%0d txns=%0d expected 0 0",
                            stall_cycles, txn_wr.size());
      end
      do_access(1'b1, 1'b0, 30'h5, 32'h0, 0);
      checks++;
      if (stall_cycles !== 0 || rdata_obs !== 32'hDEADBEEF) begin
         errors++; $display("FAIL write_hit_readback: got stall=%0d data=%h expected 0 deadbeef",
                            stall_cycles, rdata_obs);
      end
   endtask

   task automatic test_dirty_evict();
      logic [127:0] vblk;
      vblk = gblock(1);
      do_access(1'b1, 1'b0, 30'h25, 32'h0, 4);
      checks++;
      if (txn_wr.size() !== 2) begin
         errors++; $display("FAIL evict_txn_count: got %0d expected 2", txn_wr.size());
      end
      checks++;
      if (txn_wr[0] !== 1 || txn_addr[0] !== 28'h1 || txn_data[0][63:32] !== 32'hDEADBEEF
          || txn_data[0] !== vblk) begin
         errors++; $display("FAIL evict_writeback: got wr=%0d addr=%h data=%h expected write 1 data %h",
                            txn_wr[0], txn_addr[0], txn_data[0], vblk);
      end
      checks++;
      if (txn_wr[1] !== 0 || txn_addr[1] !== 28'h9) begin
         errors++; $display("FAIL evict_refill: got wr=%0d addr=%h expected read 9", txn_wr[1], txn_addr[1]);
      end
      checks++;
      if (stall_cycles !== 9 || rdata_obs !== gword('h25)) begin
         errors++; $display("FAIL evict_result: got stall=%0d data=%h expected 9 %h",
                            stall_cycles, rdata_obs, gword('h25));
      end
   endtask

   task automatic test_clean_conflict();
      do_access(1'b1, 1'b0, 30'h00, 32'h0, 3);
      checks++;
      if (txn_wr.size() !== 1 || txn_wr[0] !== 0 || txn_addr[0] !== 28'h0) begin
         errors++; $display("FAIL conflict_first: got n=%0d wr=%0d addr=%h expected 1 read at 0",
                            txn_wr.size(), txn_wr[0], txn_addr[0]);
      end
      do_access(1'b1, 1'b0, 30'h20, 32'h0, 3);
      checks++;
      if (txn_wr.size() !== 1 || txn_wr[0] !== 0 || txn_addr[0] !== 28'h8) begin
         errors++; $display("FAIL conflict_second: got n=%0d wr=%0d addr=%h expected 1 read at 8",
                            txn_wr.size(), txn_wr[0], txn_addr[0]);
      end
      checks++;
      if (stall_cycles !== 4 || rdata_obs !== gword('h20)) begin
         errors++; $display("FAIL conflict_result: got stall=%0d data=%h expected 4 %h",
                            stall_cycles, rdata_obs, gword('h20));
      end
   endtask

   task automatic test_reset_mid_allocate();
      do_access(1'b0, 1'b1, 30'h21, 32'hCAFEF00D, 0);
      golden['h21] = 32'hCAFEF00D;
      proc_read = 1'b1;
      proc_write = 1'b0;
      proc_addr = 30'h45;
      #1;
      checks++;
      if (proc_stall !== 1'b1) begin
         errors++; $display("FAIL midrst_miss_stall: got %b expected 1", proc_stall);
      end
      @(negedge clk);
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== 28'h11) begin
         errors++; $display("FAIL midrst_allocate: got rd=%b addr=%h expected 1 11", mem_read, mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      proc_read = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || proc_stall !== 1'b0) begin
         errors++; $display("FAIL midrst_idle: got rd=%b wr=%b stall=%b expected 0 0 0",
                            mem_read, mem_write, proc_stall);
      end
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      do_access(1'b1, 1'b0, 30'h45, 32'h0, 2);
      checks++;
      if (txn_wr.size() !== 1 || txn_wr[0] !== 0 || txn_addr[0] !== 28'h11
          || rdata_obs !== init_word('h45)) begin
         errors++; $display("FAIL midrst_reread: got n=%0d addr=%h data=%h expected 1 read 11 data %h",
                            txn_wr.size(), txn_addr[0], rdata_obs, init_word('h45));
      end
      do_access(1'b1, 1'b0, 30'h21, 32'h0, 2);
      checks++;
      if (txn_wr.size() !== 1 || txn_wr[0] !== 0 || rdata_obs !== init_word('h21)) begin
         errors++; $display("FAIL midrst_dirty_lost: got n=%0d wr=%0d data=%h expected 1 read data %h",
                            txn_wr.size(), txn_wr[0], rdata_obs, init_word('h21));
      end
   endtask

   task automatic test_back_to_back();
      logic [29:0] a;
      for (int i = 0; i < 8; i++) begin
         a = (30'd3 << 5) | 30'(i << 2);
         do_access(1'b1, 1'b0, a, 32'h0, 0);
      end
      proc_read = 1'b0;
      proc_write = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_ready = 1'b1;
         #1;
         checks++;
         if (mem_read !== 1'b0 || mem_write !== 1'b0 || proc_stall !== 1'b0) begin
            errors++; $display("FAIL stray_ready: got rd=%b wr=%b stall=%b expected 0 0 0",
                               mem_read, mem_write, proc_stall);
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a = (30'd3 << 5) | 30'(i << 2) | 30'(i % 4);
         do_access(1'b1, 1'b0, a, 32'h0, 0);
         checks++;
         if (stall_cycles !== 0 || txn_wr.size() !== 0 || rdata_obs !== gword(int'(a))) begin
            errors++; $display("FAIL b2b_hit_%0d: got stall=%0d txns=%0d data=%h expected 0 0 %h",
                               i, stall_cycles, txn_wr.size(), rdata_obs, gword(int'(a)));
         end
      end
   endtask

   task automatic test_random();
      int sel, vict, exp_n, exp_stall, k;
      bit rd, wr, hit;
      logic [29:0] addr;
      logic [31:0] wd;
      logic [2:0] idx;
      logic [24:0] tg;
      logic [127:0] vblk;
      apply_reset();
      for (int n = 0; n < 300; n++) begin
         sel  = int'($urandom_range(0, 7));
         rd   = (sel < 4) || (sel == 7);
         wr   = (sel >= 4);
         addr = 30'($urandom_range(0, 127));
         wd   = $urandom;
         idx  = addr[4:2];
         tg   = addr[29:5];
         hit  = m_valid[idx] && (m_tag[idx] == tg);
         vict = int'({m_tag[idx], idx});
         vblk = gblock(vict);
         exp_n = hit ? 0 : (m_dirty[idx] ? 2 : 1);
         do_access(rd, wr, addr, wd, 0);
         checks++;
         if (timeout || proto_err || txn_wr.size() !== exp_n) begin
            errors++; $display("FAIL rand_%0d_txns: got n=%0d timeout=%b proto=%b expected n=%0d",
                               n, txn_wr.size(), timeout, proto_err, exp_n);
         end else if (exp_n > 0) begin
            k = 0;
            if (exp_n == 2) begin
               checks++;
               if (txn_wr[0] !== 1 || txn_addr[0] !== 28'(vict) || txn_data[0] !== vblk) begin
                  errors++; $display("FAIL rand_%0d_writeback: got wr=%0d addr=%h data=%h expected write %h data %h",
                                     n, txn_wr[0], txn_addr[0], txn_data[0], 28'(vict), vblk);
               end
               k = 1;
            end
            checks++;
            if (txn_wr[k] !== 0 || txn_addr[k] !== addr[29:2]) begin
               errors++; $display("FAIL rand_%0d_refill: got wr=%0d addr=%h expected read %h",
                                  n, txn_wr[k], txn_addr[k], addr[29:2]);
            end
         end
         exp_stall = 0;
         if (!hit) begin
            exp_stall = 1;
            foreach (txn_lat[j]) exp_stall += txn_lat[j];
         end
         checks++;
         if (stall_cycles !== exp_stall) begin
            errors++; $display("FAIL rand_%0d_stall: got %0d expected %0d", n, stall_cycles, exp_stall);
         end
         if (rd && !wr) begin
            checks++;
            if (rdata_obs !== gword(int'(addr))) begin
               errors++; $display("FAIL rand_%0d_rdata: addr %h got %h expected %h",
                                  n, addr, rdata_obs, gword(int'(addr)));
            end
         end
         if (!hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
         end
         if (wr) begin
            golden[int'(addr)] = wd;
            m_dirty[idx] = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) begin
            proc_read = 1'b0;
            proc_write = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_cold_read();
      test_write_hit();
      test_dirty_evict();
      test_clean_conflict();
      test_reset_mid_allocate();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_wb_dm.md
Name: dcache_wb_dm

Overview:
- Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the pipeline's MEM stage.
- Consumes the DCACHE_ren/wen/addr/wdata interface and returns DCACHE_rdata/DCACHE_stall.
- Refills and evicts whole 4-word blocks over a 128-bit handshake bus to the slow main memory.
- Hits complete with zero stall cycles; misses hold DCACHE_stall high until the block is resident.

Parameters:
- NUM_BLOCKS, 8, number of cache lines. Power of two; index width is log2(NUM_BLOCKS).
- WORDS_PER_BLOCK, 4, 32-bit words per line. Fixed at 4 because the memory bus is 128 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset (port name kept for consistency).
- proc_read  input  1  load request; driven from DCACHE_ren.
- proc_write  input  1  store request; driven from DCACHE_wen.
- proc_addr  input  30  word address: [1:0] word offset, [4:2] index, [29:5] tag (25 bits).
- proc_wdata  input  32  store data.
- proc_rdata  output  32  load data; valid when proc_read=1 and proc_stall=0.
- proc_stall  output  1  high while the request is not yet serviced.
- mem_read  output  1  block refill request.
- mem_write  output  1  block write-back request.
- mem_addr  output  28  block address.
- mem_wdata  output  128  victim block data; word 0 occupies bits [31:0].
- mem_rdata  input  128  refill block data; word 0 occupies bits [31:0].
- mem_ready  input  1  one-cycle pulse completing the current mem_read or mem_write.

Behaviour:
- Storage per line: valid, dirty, 25-bit tag, 128-bit data.
- Reset: all valid and dirty bits clear; FSM to IDLE; mem_read=0, mem_write=0, proc_stall=0, proc_rdata=0. Tags and data are don't-care.
- hit = valid[idx] && tag[idx]==proc_addr[29:5]. Evaluated combinationally in IDLE.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: proc_stall=0, no memory traffic.
- IDLE, read hit: proc_rdata = the selected word, same cycle; proc_stall=0.
- IDLE, write hit: proc_stall=0; the word is written at the clock edge and dirty[idx] is set.
- IDLE, miss with dirty[idx]=0: proc_stall=1; next state ALLOCATE.
- IDLE, miss with dirty[idx]=1: proc_stall=1; next state WRITEBACK.
- WRITEBACK: mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx], all held stable. On mem_ready, go to ALLOCATE.
- ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready: data[idx]=mem_rdata, tag updated, valid=1, dirty=0; go to IDLE.
  - The request is then serviced as a hit in IDLE, where a write sets dirty.
- Stall timing: proc_stall is high in WRITEBACK and ALLOCATE, and in IDLE on a miss.
- Miss latency: clean miss = memory latency + 1 hit cycle. Dirty miss adds the write-back latency.
- mem_read and mem_write are never both high. A request drops the cycle after its mem_ready.
- The processor holds addr, data and request stable while stalled; the cache does not latch them.
- proc_read and proc_write both high: treated as a write; proc_rdata is don't-care.
- mem_ready while in IDLE: ignored.
- Reset in any state: back to IDLE next cycle, memory requests dropped, all lines invalidated. Dirty data is lost by design.
- Index wrap: the index comes only from proc_addr[4:2]. Addresses 0x00 and 0x20 (word) conflict on line 0.

Test Plan:
- Cold read, proc_addr=0x0000_0005, memory latency 4 -> ALLOCATE with mem_addr=0x1. proc_stall stays high until the cycle after mem_ready. Then proc_rdata = word 1 of the refill block and proc_stall=0.
- Write hit, addr 0x5 after refill, wdata=0xDEADBEEF -> no stall, dirty[1]=1. A following read of 0x5 returns 0xDEADBEEF with zero stall.
- Dirty eviction: read 0x25 after the previous case -> WRITEBACK first with mem_addr=0x1 and mem_wdata[63:32]=0xDEADBEEF, then ALLOCATE with mem_addr=0x9, then a hit.
- Clean conflict miss: read 0x00 and then 0x20, with no writes -> no mem_write pulse; a single ALLOCATE with mem_addr=0x8.
- Reset asserted mid-ALLOCATE -> next cycle mem_read=0, proc_stall=0, FSM in IDLE. A re-read of the same address misses again.
- Back-to-back hits: 8 consecutive read hits over indices 0-7 -> proc_stall=0 on every cycle and no memory traffic.
